// File: rtl/qspi_cmd_pkg.sv
// qspi_cmd_pkg
//   Shared definitions for the QSPI command sequencer: frame opcodes,
//   the sequencer state encoding and the byte the slave sends when no
//   read data is ready.
package qspi_cmd_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    // Byte the slave shifts out on an underrun; the sequencer never drives it.
    localparam logic [7:0] TX_FILL  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_LEN      = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_RD_FETCH = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_RD_HOLD  = 3'd6,
        ST_DRAIN    = 3'd7
    } state_t;

endpackage

// File: rtl/qspi_tx_stage.sv
// qspi_tx_stage
//   One-entry holding register between the sequencer and the slave's
//   transmit shifter.
//   Ports:
//     i_clk, i_reset     clock, synchronous active-high reset
//     i_load, i_load_data  capture a fetched read byte
//     i_tx_req           slave takes the held byte (consume)
//     i_flush            drop the held byte (frame aborted)
//     o_tx_data          held byte, 0x00 whenever nothing is held
//     o_tx_valid         a byte is held
//     o_tx_underrun      one-cycle pulse: i_tx_req arrived with nothing held
module qspi_tx_stage (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_load_data,
    input  logic       i_tx_req,
    input  logic       i_flush,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_tx_underrun
);

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_underrun;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= i_tx_req && !r_valid;
            // Flush and consume both empty the stage; data returns to 0x00.
            if (i_flush || (i_tx_req && r_valid)) begin
                r_data  <= 8'h00;
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_data  <= i_load_data;
                r_valid <= 1'b1;
            end
        end
    end

    assign o_tx_data     = r_data;
    assign o_tx_valid    = r_valid;
    assign o_tx_underrun = r_underrun;

endmodule

// File: rtl/qspi_cmd_sequencer.sv
// qspi_cmd_sequencer
//   Parses chip-select framed QSPI byte streams (opcode, address, length,
//   data) and turns them into register write strobes or prefetched register
//   reads handed to the slave's transmit shifter.
//   Ports:
//     i_clk, i_reset        clock, synchronous active-high reset
//     i_cs_active           chip select, high while a frame is open
//     i_rx_valid, i_rx_data received byte strobe and value
//     i_tx_req              slave latches o_tx_data
//     o_tx_data, o_tx_valid read byte offered to the slave
//     o_reg_addr/wdata/we/re register bus; i_reg_rdata valid one cycle after o_reg_re
//     o_frame_done          pulse: frame completed all N transfers
//     o_frame_err           pulse: frame rejected or aborted
//     o_tx_underrun         pulse: i_tx_req with o_tx_valid low
//     o_dbg_state           current sequencer state
//   Handshakes: every strobe (rx_valid, tx_req, reg_we, reg_re and the
//   pulses) is a single-cycle event with no back-pressure; a byte is taken
//   in the cycle its strobe is high.
module qspi_cmd_sequencer
    import qspi_cmd_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BURST_MAX = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cs_active,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic              i_tx_req,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic              o_tx_underrun,
    output logic [2:0]        o_dbg_state
);

    localparam int         CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [7:0] LEN_MAX = 8'(BURST_MAX);

    state_t            r_state;
    logic              r_is_read;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_we;
    logic              r_reg_re;
    logic              r_frame_done;
    logic              r_frame_err;

    logic w_len_bad;
    logic w_tx_load;
    logic w_tx_flush;
    logic w_consume;

    assign w_len_bad  = (i_rx_data == 8'h00) || (i_rx_data > LEN_MAX);
    // Read data arrives in RD_WAIT, one cycle after the RD_FETCH strobe.
    assign w_tx_load  = (r_state == ST_RD_WAIT) && i_cs_active;
    assign w_tx_flush = !i_cs_active;
    assign w_consume  = (r_state == ST_RD_HOLD) && i_cs_active && i_tx_req && o_tx_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_is_read    <= 1'b0;
            r_addr       <= '0;
            r_count      <= '0;
            r_reg_addr   <= '0;
            r_reg_wdata  <= 8'h00;
            r_reg_we     <= 1'b0;
            r_reg_re     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_reg_we     <= 1'b0;
            r_reg_re     <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            // Chip-select release beats any byte arriving in the same cycle.
            if (!i_cs_active) begin
                if (r_state != ST_IDLE && r_state != ST_DRAIN)
                    r_frame_err <= 1'b1;
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (i_rx_valid) begin
                        if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) begin
                            r_is_read <= (i_rx_data == OP_READ);
                            r_state   <= ST_ADDR;
                        end else begin
                            r_frame_err <= (i_rx_data != OP_NOP);
                            r_state     <= ST_DRAIN;
                        end
                    end
                    ST_ADDR: if (i_rx_valid) begin
                        r_addr  <= ADDR_W'(i_rx_data);
                        r_state <= ST_LEN;
                    end
                    ST_LEN: if (i_rx_valid) begin
                        if (w_len_bad) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_DRAIN;
                        end else begin
                            r_count <= CNT_W'(i_rx_data);
                            if (r_is_read) begin
                                // Strobe is registered so it is high while in RD_FETCH.
                                r_reg_re   <= 1'b1;
                                r_reg_addr <= r_addr;
                                r_state    <= ST_RD_FETCH;
                            end else begin
                                r_state <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_WR_DATA: if (i_rx_valid) begin
                        r_reg_we    <= 1'b1;
                        r_reg_wdata <= i_rx_data;
                        r_reg_addr  <= r_addr;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_count     <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DRAIN;
                        end
                    end
                    ST_RD_FETCH: r_state <= ST_RD_WAIT;
                    ST_RD_WAIT:  r_state <= ST_RD_HOLD;
                    ST_RD_HOLD: if (w_consume) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_DRAIN;
                        end else begin
                            r_reg_re   <= 1'b1;
                            r_reg_addr <= r_addr + ADDR_W'(1);
                            r_state    <= ST_RD_FETCH;
                        end
                    end
                    ST_DRAIN: r_state <= ST_DRAIN;
                    default:  r_state <= ST_IDLE;
                endcase
            end
        end
    end

    qspi_tx_stage u_tx_stage (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_load        (w_tx_load),
        .i_load_data   (i_reg_rdata),
        .i_tx_req      (i_tx_req),
        .i_flush       (w_tx_flush),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .o_tx_underrun (o_tx_underrun)
    );

    assign o_reg_addr   = r_reg_addr;
    assign o_reg_wdata  = r_reg_wdata;
    assign o_reg_we     = r_reg_we;
    assign o_reg_re     = r_reg_re;
    assign o_frame_done = r_frame_done;
    assign o_frame_err  = r_frame_err;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// tb_qspi_cmd_sequencer
//   Bench for qspi_cmd_sequencer: frame table plus hand-written read,
//   underrun, burst-limit and reset sequences; register writes and read
//   bytes are checked against an expected queue.
module tb_qspi_cmd_sequencer;
    import qspi_cmd_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_done;
    logic       frame_err;
    logic       tx_underrun;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    qspi_cmd_sequencer #(.ADDR_W(8), .BURST_MAX(16)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cs_active   (cs_active),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .i_tx_req      (tx_req),
        .o_tx_data     (tx_data),
        .o_tx_valid    (tx_valid),
        .o_reg_addr    (reg_addr),
        .o_reg_wdata   (reg_wdata),
        .o_reg_we      (reg_we),
        .o_reg_re      (reg_re),
        .i_reg_rdata   (reg_rdata),
        .o_frame_done  (frame_done),
        .o_frame_err   (frame_err),
        .o_tx_underrun (tx_underrun),
        .o_dbg_state   (dbg_state)
    );

    // Register file model: read data is addr ^ 0x5A, one cycle after reg_re.
    always @(posedge clk) if (reg_re) reg_rdata <= reg_addr ^ 8'h5A;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt = 0, re_cnt = 0, done_cnt = 0, err_cnt = 0, und_cnt = 0;
    bit overlap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, reg_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("write_addr_data", {16'h0, reg_addr, reg_wdata}, {16'h0, e});
            end
        end
        if (reg_re)      re_cnt++;
        if (frame_done)  done_cnt++;
        if (frame_err)   err_cnt++;
        if (tx_underrun) und_cnt++;
        if (reg_we && reg_re) overlap = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts;
        we_cnt = 0; re_cnt = 0; done_cnt = 0; err_cnt = 0; und_cnt = 0;
    endtask

    task automatic cs_open;
        @(negedge clk); cs_active = 1'b1;
        @(negedge clk);
    endtask

    task automatic cs_close;
        @(negedge clk); cs_active = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_valid = 1'b1; rx_data = b;
        @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
    endtask

    task automatic pulse_tx_req;
        @(negedge clk); tx_req = 1'b1;
        @(negedge clk); tx_req = 1'b0;
    endtask

    task automatic wait_tx_valid(input string name);
        int n;
        n = 0;
        while (!tx_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [7:0] get_byte(input logic [63:0] v, input int i);
        return v[63-8*i -: 8];
    endfunction

    // ---------------- frame table ----------------
    typedef struct {
        logic [63:0] bytes;   // left-justified, byte 0 in bits 63:56
        int          nb;
        int          exp_we;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [7:0] rd_exp[$];
        logic [7:0] e8;
        logic [7:0] d;

        vecs[0] = '{64'h01_10_03_AA_BB_CC_DD_00, 7, 3, 1, 0}; // write, trailing byte ignored
        vecs[1] = '{64'h07_11_22_00_00_00_00_00, 3, 0, 0, 1}; // bad opcode
        vecs[2] = '{64'h01_20_00_33_00_00_00_00, 4, 0, 0, 1}; // length 0
        vecs[3] = '{64'h01_20_11_33_44_00_00_00, 5, 0, 0, 1}; // length 17
        vecs[4] = '{64'h00_55_66_00_00_00_00_00, 3, 0, 0, 0}; // NOP, silent drain
        vecs[5] = '{64'h01_FF_02_12_34_00_00_00, 5, 2, 1, 0}; // address wrap
        vecs[6] = '{64'h01_40_04_01_02_00_00_00, 5, 2, 0, 1}; // CS drops after 2 of 4
        vecs[7] = '{64'h01_41_01_5C_00_00_00_00, 4, 1, 1, 0}; // next frame is fine
        vecs[8] = '{64'h02_30_00_00_00_00_00_00, 3, 0, 0, 1}; // read length 0

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_data",  {24'h0, tx_data},   32'h0);
        check("rst_tx_valid", {31'h0, tx_valid},  32'h0);
        check("rst_reg_addr", {24'h0, reg_addr},  32'h0);
        check("rst_wdata",    {24'h0, reg_wdata}, 32'h0);
        check("rst_we_re",    {30'h0, reg_we, reg_re}, 32'h0);
        check("rst_pulses",   {29'h0, frame_done, frame_err, tx_underrun}, 32'h0);
        check("rst_state",    {29'h0, dbg_state}, {29'h0, ST_IDLE});
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 9; v++) begin
            logic [7:0] len;
            logic [7:0] a;
            clear_counts();
            if (get_byte(vecs[v].bytes, 0) == OP_WRITE) begin
                len = get_byte(vecs[v].bytes, 2);
                if (len >= 8'd1 && len <= 8'd16) begin
                    for (int k = 0; k < int'(len) && 3 + k < vecs[v].nb; k++) begin
                        a = get_byte(vecs[v].bytes, 1) + 8'(k);
                        exp_q.push_back({a, get_byte(vecs[v].bytes, 3 + k)});
                    end
                end
            end
            cs_open();
            for (int i = 0; i < vecs[v].nb; i++) send_byte(get_byte(vecs[v].bytes, i));
            cs_close();
            check($sformatf("vec%0d_we", v),   we_cnt,   vecs[v].exp_we);
            check($sformatf("vec%0d_done", v), done_cnt, vecs[v].exp_done);
            check($sformatf("vec%0d_err", v),  err_cnt,  vecs[v].exp_err);
            check($sformatf("vec%0d_re", v),   re_cnt,   0);
            check($sformatf("vec%0d_q", v),    exp_q.size(), 0);
            check($sformatf("vec%0d_idle", v), {29'h0, dbg_state}, {29'h0, ST_IDLE});
        end

        // Burst of BURST_MAX writes with random data, wrapping at 0xFF
        clear_counts();
        cs_open();
        send_byte(8'h01); send_byte(8'hF8); send_byte(8'h10);
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back({8'hF8 + 8'(k), d});
            send_byte(d);
        end
        cs_close();
        check("burst_we",   we_cnt,   16);
        check("burst_done", done_cnt, 1);
        check("burst_err",  err_cnt,  0);

        // READ 02 FE 03: A4, A5, 5A with address wrap
        clear_counts();
        rd_exp.push_back(8'hA4); rd_exp.push_back(8'hA5); rd_exp.push_back(8'h5A);
        cs_open();
        send_byte(8'h02); send_byte(8'hFE); send_byte(8'h03);
        for (int k = 0; k < 3; k++) begin
            wait_tx_valid("rd");
            e8 = rd_exp.pop_front();
            check($sformatf("rd_byte%0d", k), {24'h0, tx_data}, {24'h0, e8});
            check($sformatf("rd_done_before%0d", k), done_cnt, 0);
            pulse_tx_req();
        end
        repeat (2) @(negedge clk);
        check("rd_done",      done_cnt, 1);
        check("rd_err",       err_cnt,  0);
        check("rd_re_cnt",    re_cnt,   3);
        check("rd_underrun",  und_cnt,  0);
        check("rd_tx_valid",  {31'h0, tx_valid}, 32'h0);
        check("rd_tx_data0",  {24'h0, tx_data},  32'h0);
        check("rd_drain",     {29'h0, dbg_state}, {29'h0, ST_DRAIN});
        cs_close();
        check("rd_err_close", err_cnt, 0);

        // tx_req in LEN: underrun pulse, no state change
        clear_counts();
        cs_open();
        send_byte(8'h01); send_byte(8'h60);
        check("und_in_len", {29'h0, dbg_state}, {29'h0, ST_LEN});
        pulse_tx_req();
        check("und_pulse", {31'h0, tx_underrun}, 32'h1);
        check("und_state", {29'h0, dbg_state}, {29'h0, ST_LEN});
        exp_q.push_back({8'h60, 8'h5A});
        exp_q.push_back({8'h61, 8'h66});
        send_byte(8'h02); send_byte(8'h5A); send_byte(8'h66);
        cs_close();
        check("und_cnt",  und_cnt,  1);
        check("und_we",   we_cnt,   2);
        check("und_done", done_cnt, 1);

        // Reset mid-READ in RD_HOLD
        cs_open();
        send_byte(8'h02); send_byte(8'h80); send_byte(8'h02);
        wait_tx_valid("rst_rd");
        check("mid_rd_data",  {24'h0, tx_data},   32'hDA);
        check("mid_rd_state", {29'h0, dbg_state}, {29'h0, ST_RD_HOLD});
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("mrst_tx",     {23'h0, tx_valid, tx_data}, 32'h0);
        check("mrst_addr",   {24'h0, reg_addr},  32'h0);
        check("mrst_wdata",  {24'h0, reg_wdata}, 32'h0);
        check("mrst_strobe", {27'h0, reg_we, reg_re, frame_done, frame_err, tx_underrun}, 32'h0);
        check("mrst_state",  {29'h0, dbg_state}, {29'h0, ST_IDLE});
        reset = 1'b0; cs_active = 1'b0;
        repeat (2) @(negedge clk);
        clear_counts();
        exp_q.push_back({8'h70, 8'h11});
        exp_q.push_back({8'h71, 8'h22});
        cs_open();
        send_byte(8'h01); send_byte(8'h70); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        cs_close();
        check("post_rst_we",   we_cnt,   2);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_err",  err_cnt,  0);

        // Final report
        check("we_re_overlap", {31'h0, overlap}, 32'h0);
        check("exp_q_empty",   exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
